// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : synchronise, debounce and auto-repeat an active-low push-key
// Revision     : 1.0
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic add_flag,
    output logic key_state
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_FILT = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        REL_FILT   = 3'd4
    } state_t;

    logic             key_meta;
    logic             key_sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RPT_W-1:0] rpt_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_in;
            key_sync <= key_meta;
        end
    end

    // Both counters are cleared on every transition so each state starts from zero.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rpt_cnt   <= '0;
            add_flag  <= 1'b0;
            key_state <= 1'b1;
        end else begin
            add_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_sync) begin
                        state   <= PRESS_FILT;
                        cnt     <= '0;
                        rpt_cnt <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (key_sync) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        rpt_cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= HELD;
                        cnt       <= '0;
                        rpt_cnt   <= '0;
                        add_flag  <= 1'b1;
                        key_state <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (key_sync) begin
                        state   <= REL_FILT;
                        cnt     <= '0;
                        rpt_cnt <= '0;
                    end else if (REPEAT_EN) begin
                        if (rpt_cnt == DELAY_LAST) begin
                            state    <= REPEAT;
                            cnt      <= '0;
                            rpt_cnt  <= '0;
                            add_flag <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    // A release on the terminal-count edge suppresses the pulse.
                    if (key_sync) begin
                        state   <= REL_FILT;
                        cnt     <= '0;
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == PERIOD_LAST) begin
                        rpt_cnt  <= '0;
                        add_flag <= 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                REL_FILT: begin
                    if (!key_sync) begin
                        state   <= HELD;
                        cnt     <= '0;
                        rpt_cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        rpt_cnt   <= '0;
                        key_state <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rpt_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// tb_key_debounce : directed bench with a run-length model of the debouncer
// Revision        : 1.0
// ============================================================================
module tb_key_debounce;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    typedef int iq_t[$];

    typedef struct {
        logic s1;
        logic s2;
        logic lvl;
        logic flag;
        int   run;
        int   age;
    } mst_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic key_in = 1'b1;
    logic add_flag0, key_state0, add_flag1, key_state1;

    int total = 0;
    int bad = 0;
    int edge_no = 0;
    int base = 0;

    iq_t q0, q1;
    int rise0 = -1, fall0 = -1, rise1 = -1;
    logic prev_s0 = 1'b1, prev_s1 = 1'b1;

    mst_t m0, m1;

    key_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .key_in(key_in),
        .add_flag(add_flag0), .key_state(key_state0)
    );

    key_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .key_in(key_in),
        .add_flag(add_flag1), .key_state(key_state1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    function automatic mst_t mreset();
        mst_t r;
        r.s1 = 1'b1; r.s2 = 1'b1; r.lvl = 1'b1; r.flag = 1'b0; r.run = 0; r.age = 0;
        return r;
    endfunction

    // lvl flips once the synchronised key has disagreed with it for D+1 edges;
    // age counts held edges since the last press/re-hold and drives repeats.
    function automatic mst_t step(mst_t m, logic key, bit ren);
        mst_t n = m;
        logic ks = m.s2;
        n.s2 = m.s1;
        n.s1 = key;
        n.flag = 1'b0;
        if (m.lvl) begin
            if (!ks) begin
                n.run = m.run + 1;
                if (n.run == D + 1) begin
                    n.lvl = 1'b0; n.flag = 1'b1; n.run = 0; n.age = 0;
                end
            end else begin
                n.run = 0;
            end
        end else begin
            if (ks) begin
                n.run = m.run + 1;
                n.age = 0;
                if (n.run == D + 1) begin
                    n.lvl = 1'b1; n.run = 0;
                end
            end else if (m.run > 0) begin
                n.run = 0; n.age = 0;
            end else begin
                n.age = m.age + 1;
                if (ren && (n.age == RD || (n.age > RD && (n.age - RD) % RP == 0)))
                    n.flag = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= mreset();
            m1 <= mreset();
        end else begin
            m0 <= step(m0, key_in, 1'b0);
            m1 <= step(m1, key_in, 1'b1);
        end
    end

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus absolute-edge event logging.
    always @(negedge clk) begin
        check("flag0", int'(add_flag0), int'(m0.flag));
        check("state0", int'(key_state0), int'(m0.lvl));
        check("flag1", int'(add_flag1), int'(m1.flag));
        check("state1", int'(key_state1), int'(m1.lvl));
        if (add_flag0) q0.push_back(edge_no);
        if (add_flag1) q1.push_back(edge_no);
        if (key_state0 && !prev_s0) rise0 = edge_no;
        if (!key_state0 && prev_s0) fall0 = edge_no;
        if (key_state1 && !prev_s1) rise1 = edge_no;
        prev_s0 = key_state0;
        prev_s1 = key_state1;
    end

    function automatic iq_t since(iq_t q, int b);
        iq_t r;
        foreach (q[i]) if (q[i] > b) r.push_back(q[i] - b);
        return r;
    endfunction

    task automatic chk_pulses(string name, iq_t got, iq_t exp);
        check({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size()) check(name, got[i], exp[i]);
    endtask

    task automatic hold(logic v, int n);
        key_in = v;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        iq_t e;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;

        // Reset held with the key toggling
        for (int i = 0; i < 6; i++) begin
            hold(logic'(i % 2), 1);
            check("rst_flag1", int'(add_flag1), 0);
            check("rst_state1", int'(key_state1), 1);
        end
        hold(1'b0, 1);
        base = edge_no;
        rst_n = 1'b1;
        hold(1'b0, 20);
        hold(1'b1, 20);
        e = '{11};
        chk_pulses("t1_pulse1", since(q1, base), e);
        chk_pulses("t1_pulse0", since(q0, base), e);

        // Clean press, no repeat
        base = edge_no;
        hold(1'b0, 40);
        hold(1'b1, 20);
        e = '{11};
        chk_pulses("t2_pulse0", since(q0, base), e);
        check("t2_fall0", fall0 - base, 11);
        check("t2_rise0", rise0 - base, 51);

        // Press bounce
        base = edge_no;
        hold(1'b0, 5); hold(1'b1, 1); hold(1'b0, 3); hold(1'b1, 2);
        hold(1'b0, 30);
        hold(1'b1, 20);
        e = '{22};
        chk_pulses("t3_pulse0", since(q0, base), e);

        // Auto-repeat
        base = edge_no;
        hold(1'b0, 60);
        hold(1'b1, 20);
        e = '{11, 31, 36, 41, 46, 51, 56, 61};
        chk_pulses("t4_pulse1", since(q1, base), e);

        // Release bounce while held
        base = edge_no;
        hold(1'b0, 15); hold(1'b1, 4); hold(1'b0, 3);
        hold(1'b1, 30);
        e = '{11};
        chk_pulses("t5a_pulse1", since(q1, base), e);
        check("t5a_rise1", rise1 - base, 33);

        // Release bounce then long hold: repeat timer restarts from the re-hold
        base = edge_no;
        hold(1'b0, 15); hold(1'b1, 4); hold(1'b0, 25);
        hold(1'b1, 20);
        e = '{11, 42};
        chk_pulses("t5b_pulse1", since(q1, base), e);

        // Reset mid-repeat
        base = edge_no;
        hold(1'b0, 38);
        rst_n = 1'b0;
        #1;
        check("t6_flag1", int'(add_flag1), 0);
        check("t6_state1", int'(key_state1), 1);
        check("t6_state0", int'(key_state0), 1);
        hold(1'b0, 3);
        base = edge_no;
        rst_n = 1'b1;
        hold(1'b0, 20);
        e = '{11};
        chk_pulses("t6_pulse1", since(q1, base), e);
        hold(1'b1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
# key_debounce

Input conditioning stage that turns a raw, bouncing, active-low push-button into a clean single-cycle `add_flag` pulse for the 7-segment hex counter display stage. It synchronises the key to `sys_clk`, filters bounce with a stability counter, and emits one pulse per press. An optional auto-repeat emits further pulses while the key stays held.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required to accept a press or a release (20 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY`, default 25_000_000: held cycles after the accepted press before the first repeat pulse; must be ≥ 2.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent repeat pulses; must be ≥ 2.
- `REPEAT_EN`, default 1: 1 enables auto-repeat; 0 gives one pulse per press only.

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `key_in`  in  1  raw button, asynchronous, 0 = pressed.
- `add_flag`  out  1  registered one-cycle pulse per accepted press or repeat.
- `key_state`  out  1  registered debounced level, 0 = pressed.

## Operation
- **Synchroniser:** two flops, `key_in` → `key_sync`. Both flops reset to 1 (released).
- **Counters:**
  - `cnt` is sized `$clog2(DEBOUNCE_CYCLES)`.
  - `rpt_cnt` is sized `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))`.
  - Neither counter ever wraps. Each is cleared on every state entry.
- **FSM**, reset state IDLE:
  - **IDLE:** when `key_sync` = 0, go to PRESS_FILT with `cnt` = 0.
  - **PRESS_FILT:** `cnt` increments while `key_sync` = 0.
    - If `key_sync` = 1, return to IDLE with no pulse.
    - When `cnt` = DEBOUNCE_CYCLES−1 and `key_sync` is still 0, go to HELD with `add_flag` = 1 and `key_state` = 0.
  - **HELD:** if `key_sync` = 1, go to REL_FILT.
    - Otherwise, when REPEAT_EN = 1, `rpt_cnt` increments.
    - At `rpt_cnt` = REPEAT_DELAY−1, pulse `add_flag` and go to REPEAT.
  - **REPEAT:** if `key_sync` = 1, go to REL_FILT.
    - Otherwise `rpt_cnt` increments; at REPEAT_PERIOD−1, pulse `add_flag` and clear `rpt_cnt`.
  - **REL_FILT:** `cnt` increments while `key_sync` = 1.
    - If `key_sync` = 0, return to HELD with `rpt_cnt` = 0 and no pulse.
    - At `cnt` = DEBOUNCE_CYCLES−1, go to IDLE with `key_state` = 1.
- **Release priority:** a release seen on the same edge as a repeat terminal count wins. The FSM goes to REL_FILT and no pulse is emitted.
- **No release pulse:** the release never produces `add_flag`.
- **Reset values:**
  - `add_flag` = 0, `key_state` = 1.
  - Synchroniser = 1, FSM = IDLE, `cnt` = `rpt_cnt` = 0.
  - Reset mid-press drops everything immediately. A key still held after reset is treated as a new press.

## Timing
Edges are numbered from the first edge that samples `key_in` = 0.
- **Synchroniser:** `key_sync` = 0 after edge 2.
- **Filter start:** state is PRESS_FILT with `cnt` = 0 after edge 3.
- **Press accepted:** at edge D+3 (D = DEBOUNCE_CYCLES), `add_flag` goes to 1 and `key_state` goes to 0. `add_flag` returns to 0 at edge D+4.
- **First repeat:** at edge D+3+REPEAT_DELAY.
- **Later repeats:** every REPEAT_PERIOD edges after that.
- **Release:** `key_in` = 1 first sampled at edge r gives REL_FILT after edge r+2. `key_state` goes to 1 at edge r+2+D.
- **Pulse width:** `add_flag` is never high for two consecutive cycles.

## Test plan
Unless a scenario says otherwise, parameters are D = 8, REPEAT_DELAY = 20, REPEAT_PERIOD = 5.
1. **Reset:** hold `sys_rst_n` low with `key_in` toggling → `add_flag` = 0 and `key_state` = 1 throughout. Deassert reset with `key_in` held 0 → one pulse at edge 11 after the first low sample.
2. **Clean press, no repeat:** REPEAT_EN = 0, `key_in` low for 40 cycles, then high → exactly one `add_flag` pulse at edge 11. `key_state` = 0 from edge 11 and returns to 1 at release edge r+10.
3. **Press bounce:** pattern low 5 cycles, high 1, low 3, high 2, then low 30 → no pulse during the bounce. One pulse D+3 edges after the final low run begins.
4. **Auto-repeat:** REPEAT_EN = 1, `key_in` low from edge 1 through edge 60 → 8 pulses, at edges 11, 31, 36, 41, 46, 51, 56 and 61. No pulse after the release.
5. **Release bounce:** while HELD, `key_in` high 4 cycles, low 3, then high → `key_state` stays 0 with no extra pulse. The repeat timer restarts. `key_state` goes to 1 D+2 edges after the final rise is sampled.
6. **Reset mid-repeat:** assert `sys_rst_n` low during REPEAT → `add_flag` = 0 and `key_state` = 1 immediately. After release of reset with the key still held, the first pulse follows D+3 edges later.
